// File: rtl/uart_pkg.sv
// Constants and the transmit FSM state type shared by the UART transmit and receive halves.
// One 8N1 framing definition for both directions.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_ticker.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// Wraps explicitly on bit_end, so every serial bit lasts exactly CLKS_PER_BIT cycles.
module uart_baud_ticker #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST_TICK = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_tick_cnt <= '0;
        end else if (i_enable) begin
            r_tick_cnt <= o_bit_end ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign o_bit_end = (r_tick_cnt == LAST_TICK);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one-entry holding buffer behind a valid/ready port feeding an LSB-first shifter.
// Frames are sent back to back with no idle gap when the buffer is refilled in time.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_data_valid,
    output logic                      tx_ready,
    output logic                      tx_serial,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_state_next;
    logic [UART_DATA_BITS-1:0] r_buf_data;
    logic                      r_buf_full;
    logic                      r_tx_ready;
    logic [UART_DATA_BITS-1:0] r_shifter;
    logic [UART_DATA_BITS-1:0] w_shifter_next;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_next;
    logic [0:0]                r_stop_idx;
    logic [0:0]                w_stop_idx_next;
    logic                      r_tx_serial;
    logic                      w_serial_next;
    logic                      w_take;
    logic                      w_accept;
    logic                      w_bit_end;
    logic                      w_tx_done;

    uart_baud_ticker #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ticker (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == IDLE),
        .i_enable  (r_state != IDLE),
        .o_bit_end (w_bit_end)
    );

    assign w_accept = tx_data_valid && r_tx_ready;

    // Accept and take are mutually exclusive: accept needs an empty buffer, take a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_tx_ready <= 1'b1;
            r_buf_data <= '0;
        end else if (w_take) begin
            r_buf_full <= 1'b0;
            r_tx_ready <= 1'b1;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_tx_ready <= 1'b0;
            r_buf_data <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shifter   <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= '0;
            r_tx_serial <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_shifter   <= w_shifter_next;
            r_bit_idx   <= w_bit_idx_next;
            r_stop_idx  <= w_stop_idx_next;
            r_tx_serial <= w_serial_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shifter_next  = r_shifter;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_take          = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_buf_full) begin
                    w_take         = 1'b1;
                    w_shifter_next = r_buf_data;
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shifter_next = {1'b0, r_shifter[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next    = STOP;
                        w_bit_idx_next  = '0;
                        w_stop_idx_next = '0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_stop_idx == LAST_STOP) begin
                        // Chain straight into the next start bit if a byte is waiting.
                        if (r_buf_full) begin
                            w_take         = 1'b1;
                            w_shifter_next = r_buf_data;
                            w_state_next   = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_stop_idx_next = r_stop_idx + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level follows the next state so the serial flop changes with the state register.
    always_comb begin
        w_serial_next = 1'b1;
        w_tx_done     = 1'b0;
        case (w_state_next)
            START:   w_serial_next = 1'b0;
            DATA:    w_serial_next = w_shifter_next[0];
            default: w_serial_next = 1'b1;
        endcase
        if (r_state == STOP && w_bit_end && r_stop_idx == LAST_STOP) begin
            w_tx_done = 1'b1;
        end
    end

    assign tx_ready  = r_tx_ready;
    assign tx_serial = r_tx_serial;
    assign tx_busy   = (r_state != IDLE);
    assign tx_done   = w_tx_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: idle, single frame, back-to-back, backpressure,
// reset abort and decoded loopback with one and two stop bits.
module tb_uart_transmitter;

    localparam int CPB  = 16;
    localparam int CPB2 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_serial, tx_busy, tx_done;
    logic       tx_ready2, tx_serial2, tx_busy2, tx_done2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_valid),
        .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_transmitter #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_data_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_serial(tx_serial2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic rdy(input int sel);
        return (sel != 0) ? tx_ready2 : tx_ready;
    endfunction

    function automatic logic line(input int sel);
        return (sel != 0) ? tx_serial2 : tx_serial;
    endfunction

    function automatic logic [9:0] levels_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic offer(input int sel, input logic [7:0] b);
        int n = 0;
        while (rdy(sel) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("offer_%0d_%02h_ready", sel, b), 32'(rdy(sel)), 32'd1);
        if (sel == 0) begin
            tx_data  = b;
            tx_valid = 1'b1;
        end else begin
            tx_data2  = b;
            tx_valid2 = 1'b1;
        end
        @(negedge clk);
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    // Watches 160 consecutive cycles of dut starting at the next negedge.
    task automatic watch_frame(input logic [9:0] lv, input string tag);
        int eq_cnt;
        int done_cnt = 0;
        int done_at  = -1;
        int busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            eq_cnt = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx_serial === lv[i]) eq_cnt++;
                if (tx_busy === 1'b1) busy_cnt++;
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    done_at = i * CPB + c;
                end
            end
            chk($sformatf("%s_bit%0d_cycles", tag, i), 32'(eq_cnt), 32'(CPB));
        end
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd159);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd160);
    endtask

    // Mid-bit sampling receiver for either instance.
    task automatic rx(input int sel, output logic [7:0] d, output logic ferr);
        int n   = 0;
        int cpb = (sel != 0) ? CPB2 : CPB;
        int nst = (sel != 0) ? 2 : 1;
        d    = '0;
        ferr = 1'b0;
        while (line(sel) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) ferr = 1'b1;
        repeat (cpb / 2) @(negedge clk);
        if (line(sel) !== 1'b0) ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            d[i] = line(sel);
        end
        for (int s = 0; s < nst; s++) begin
            repeat (cpb) @(negedge clk);
            if (line(sel) !== 1'b1) ferr = 1'b1;
        end
    endtask

    task automatic loopback(input int sel);
        logic [7:0] bytes [4];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h80;
        bytes[3] = 8'h01;
        fork
            begin
                for (int i = 0; i < 4; i++) offer(sel, bytes[i]);
            end
            begin
                logic [7:0] got;
                logic       ferr;
                for (int i = 0; i < 4; i++) begin
                    rx(sel, got, ferr);
                    chk($sformatf("loop%0d_byte%0d", sel, i), 32'(got), 32'(bytes[i]));
                    chk($sformatf("loop%0d_ferr%0d", sel, i), 32'(ferr), 32'd0);
                end
            end
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        tx_data   = '0;
        tx_data2  = '0;

        // 1: reset values and quiet idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_ready",  32'(tx_ready),  32'd1);
        chk("rst_busy",   32'(tx_busy),   32'd0);
        chk("rst_done",   32'(tx_done),   32'd0);
        chk("rst2_serial", 32'(tx_serial2), 32'd1);
        chk("rst2_ready",  32'(tx_ready2),  32'd1);
        rst = 1'b0;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_serial === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0) n++;
        end
        chk("idle_50_cycles", 32'(n), 32'd50);

        // 2: single byte 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        offer(0, 8'hA5);
        chk("a5_line_before_start", 32'(tx_serial), 32'd1);
        chk("a5_ready_while_full",  32'(tx_ready),  32'd0);
        watch_frame(10'b1101001010, "a5");
        @(negedge clk);
        chk("a5_idle_serial", 32'(tx_serial), 32'd1);
        chk("a5_idle_busy",   32'(tx_busy),   32'd0);
        chk("a5_idle_ready",  32'(tx_ready),  32'd1);

        // 3: back-to-back 0x55, 0x0F with no gap
        offer(0, 8'h55);
        fork
            begin
                watch_frame(levels_of(8'h55), "b2b_55");
                watch_frame(levels_of(8'h0F), "b2b_0f");
            end
            begin
                int k = 0;
                offer(0, 8'h0F);
                while (tx_ready !== 1'b1 && k < 1000) begin
                    k++;
                    @(negedge clk);
                end
                chk("b2b_ready_low_cycles", 32'(k), 32'd159);
            end
        join
        @(negedge clk);
        chk("b2b_idle_busy", 32'(tx_busy), 32'd0);

        // 4: backpressure; data changes from 0x3C to 0xC3 before acceptance
        offer(0, 8'h11);
        fork
            begin
                int m = 0;
                watch_frame(levels_of(8'h11), "bp_11");
                watch_frame(levels_of(8'h22), "bp_22");
                watch_frame(levels_of(8'hC3), "bp_c3");
                repeat (60) begin
                    @(negedge clk);
                    if (tx_serial === 1'b1 && tx_busy === 1'b0) m++;
                end
                chk("bp_no_duplicate_idle", 32'(m), 32'd60);
            end
            begin
                int k = 0;
                offer(0, 8'h22);
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                chk("bp_ready_low", 32'(tx_ready), 32'd0);
                repeat (20) @(negedge clk);
                tx_data = 8'hC3;
                while (tx_ready !== 1'b1 && k < 1000) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_ready_returns", 32'(tx_ready), 32'd1);
                @(negedge clk);
                tx_valid = 1'b0;
                chk("bp_ready_low_after_accept", 32'(tx_ready), 32'd0);
            end
        join

        // 5: reset during data bit 4 with 0x5A buffered
        offer(0, 8'h96);
        offer(0, 8'h5A);
        repeat (84) @(negedge clk);
        chk("abort_in_bit4_level", 32'(tx_serial), 32'd1);
        chk("abort_busy_before",   32'(tx_busy),   32'd1);
        chk("abort_ready_before",  32'(tx_ready),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_serial", 32'(tx_serial), 32'd1);
        chk("abort_ready",  32'(tx_ready),  32'd1);
        chk("abort_busy",   32'(tx_busy),   32'd0);
        chk("abort_done",   32'(tx_done),   32'd0);
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_serial === 1'b1 && tx_busy === 1'b0) n++;
        end
        chk("abort_buffer_discarded", 32'(n), 32'd300);

        // 6: decoded loopback, one and two stop bits
        loopback(0);
        loopback(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
